tick_period_meter: RTL and testbench
====================================

// Module: tick_period_meter
// PURPOSE
//  Receive end of the slow-clock pulse interface. Takes a tick train (one_sec pulse or duty50 level).
//  Measures clock cycles between successive rising edges and flags a turbo-rate source.
//  Flags a stalled source (timeout) and counts ticks.
//  Sits between the slow-clock generator and game logic/debug display.
// PARAMETERS
//  CNT_W      32           width of cycle counter and period output
//  MAX_PERIOD 100_000_000  cycles without an edge before timeout (2 s @ 50 MHz); must be < 2**CNT_W
//  FAST_MAX   6_250_000    period <= FAST_MAX sets fast (turbo source measures 3_125_001)
// PORTS
//  clk          in   1      system clock
//  resetN       in   1      asynchronous active-low reset
//  tick_in      in   1      tick train; a pulse or level, only rising edges count
//  clear        in   1      synchronous clear of all state and outputs
//  period       out  CNT_W  cycles between last two accepted rising edges
//  period_valid out  1      one-cycle strobe when period/fast update
//  fast         out  1      last period <= FAST_MAX
//  timeout      out  1      sticky: no edge for MAX_PERIOD cycles
//  tick_count   out  16     rising edges seen since reset/clear, wraps 0xFFFF->0
// BEHAVIOUR
//  Interface: one clock; reset asynchronous, active-low.
//  Reset: all outputs 0, cnt 0, state IDLE, edge-detect history 0.
//  rise = s & ~s_d; s is the (optionally synchronised) tick_in and s_d its 1-cycle delay.
//   A level held high gives exactly one rise.
//  FSM IDLE / MEASURE / STALL:
//   IDLE: cnt held 0; on rise -> MEASURE, cnt<=0, no period_valid.
//   MEASURE: cnt+=1 per cycle.
//    On rise: period<=cnt+1, fast<=(cnt+1<=FAST_MAX), period_valid<=1 next cycle only, cnt<=0.
//    Edges at cycles t0,t1 give period = t1-t0.
//    No rise and cnt==MAX_PERIOD-1: -> STALL, timeout<=1, period/fast unchanged.
//   STALL: cnt held; on rise -> MEASURE, cnt<=0, timeout<=0, no period_valid.
//    The partial interval is discarded.
//  tick_count increments on every rise in every state.
//  clear has priority over everything: -> IDLE, all outputs and cnt 0.
//   A rise in the same cycle is dropped: not counted, does not start a measurement.
//   Edge history still updates, so no spurious rise after clear.
//  Rise in the same cycle cnt hits MAX_PERIOD-1: rise wins, period=MAX_PERIOD, no timeout.
//  cnt never wraps: bounded by MAX_PERIOD-1.
//  Outputs are registered; period_valid is never high on two consecutive cycles.
// CONFIGURATION
//  TICK_SYNC_EN defined: tick_in passes a 2-flop synchroniser before edge detect.
//   Asynchronous sources are allowed; rise lags tick_in by 2 extra cycles.
//   Measured period is unaffected.
//  TICK_SYNC_EN undefined: tick_in must be synchronous to clk; s = tick_in; no extra latency.
// STRUCTURE
//  Package tick_pkg: typedef enum logic [1:0] {IDLE, MEASURE, STALL} tpm_state_t;
//   localparam ONE_SEC_VAL = 50_000_000.
//  Sub-module tick_edge_detect: optional synchroniser (macro) + rise output, instantiated once.
//  FSM, counter and output registers stay in tick_period_meter.
// TESTING (MAX_PERIOD=100, FAST_MAX=10; run with and without TICK_SYNC_EN)
//  1 Reset: hold resetN=0, toggle tick_in.
//    -> all outputs 0; after release, first rise gives no period_valid, tick_count=1.
//  2 1-cycle pulses every 21 cycles.
//    -> from the 2nd pulse, period=21 and fast=0; exactly one period_valid per pulse; tick_count=N.
//  3 Pulses every 5 cycles.
//    -> period=5, fast=1; switching back to 21-cycle spacing gives fast=0 on the next valid.
//  4 One pulse, then silence.
//    -> timeout=1 exactly 100 cycles after the rise; stays 1.
//    Next pulse: timeout=0, no valid. Following pulse 21 later: period=21.
//  5 clear asserted in the same cycle as a rise, with tick_count=7.
//    -> IDLE, all outputs 0, tick_count=0. Next two rises 21 apart: one valid, period=21.
//  6 tick_in held high 30 cycles, repeated every 60 cycles (duty50 style).
//    -> one count per high phase; period=60.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared types and constants for the tick period meter.
package tick_pkg;

    typedef enum logic [1:0] {IDLE, MEASURE, STALL} tpm_state_t;

    localparam int unsigned ONE_SEC_VAL = 50_000_000;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the tick train; TICK_SYNC_EN adds a 2-flop synchroniser in front.
module tick_edge_detect (
    input  logic clk,
    input  logic resetN,
    input  logic tick_in,
    output logic rise
);

    logic s;
    logic s_d;

`ifdef TICK_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) sync <= '0;
        else         sync <= {sync[0], tick_in};
    end

    assign s = sync[1];
`else
    assign s = tick_in;
`endif

    // History keeps updating during clear so a held level cannot re-trigger afterwards.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) s_d <= 1'b0;
        else         s_d <= s;
    end

    assign rise = s & ~s_d;

endmodule

// File: rtl/tick_period_meter.sv
// Measures cycles between tick rising edges, flags turbo sources and stalls, counts ticks.
// Optional TICK_SYNC_EN macro enables input synchronisation in tick_edge_detect.
module tick_period_meter
    import tick_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_PERIOD = 2 * ONE_SEC_VAL,
    parameter int unsigned FAST_MAX   = ONE_SEC_VAL / 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             fast,
    output logic             timeout,
    output logic [15:0]      tick_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PERIOD - 1);
    localparam logic [CNT_W-1:0] FAST_LIM = CNT_W'(FAST_MAX);

    tpm_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             rise;

    tick_edge_detect u_edge (
        .clk     (clk),
        .resetN  (resetN),
        .tick_in (tick_in),
        .rise    (rise)
    );

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            fast         <= 1'b0;
            timeout      <= 1'b0;
            tick_count   <= '0;
        end else if (clear) begin
            // A rise coinciding with clear is deliberately dropped.
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            fast         <= 1'b0;
            timeout      <= 1'b0;
            tick_count   <= '0;
        end else begin
            period_valid <= 1'b0;
            if (rise) tick_count <= tick_count + 16'd1;

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) state <= MEASURE;
                end
                MEASURE: begin
                    // Rise takes precedence over the timeout on the final count.
                    if (rise) begin
                        period       <= cnt_inc;
                        fast         <= (cnt_inc <= FAST_LIM);
                        period_valid <= 1'b1;
                        cnt          <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= STALL;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                STALL: begin
                    // Partial interval is discarded; measurement restarts from this edge.
                    if (rise) begin
                        state   <= MEASURE;
                        cnt     <= '0;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter with a period scoreboard; works with or without TICK_SYNC_EN.
module tb_tick_period_meter;

    localparam int MAXP  = 100;
    localparam int FASTM = 10;
`ifdef TICK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int   per;
        logic fst;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        tick_in = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] period;
    logic        period_valid;
    logic        fast;
    logic        timeout;
    logic [15:0] tick_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rise = 0;
    bit   measuring = 0;
    int   tc_exp = 0;
    logic pv_prev = 1'b0;
    exp_t sb[$];

    tick_period_meter #(.CNT_W(32), .MAX_PERIOD(MAXP), .FAST_MAX(FASTM)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .tick_in      (tick_in),
        .clear        (clear),
        .period       (period),
        .period_valid (period_valid),
        .fast         (fast),
        .timeout      (timeout),
        .tick_count   (tick_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every valid must match the oldest expected period.
    always @(negedge clk) begin
        if (period_valid) begin
            chk("valid_not_back_to_back", pv_prev, 1'b0);
            chk("valid_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("period", period, e.per);
                chk("fast", fast, e.fst);
            end
        end
        pv_prev = period_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Drive one rising edge held high for hi cycles and record the expectation.
    task automatic rise_tick(input int hi);
        int gap;
        gap = cyc - last_rise;
        tc_exp++;
        if (measuring && gap <= MAXP) begin
            exp_t e;
            e.per = gap;
            e.fst = (gap <= FASTM);
            sb.push_back(e);
        end
        measuring = 1;
        last_rise = cyc;
        tick_in = 1'b1;
        repeat (hi) step();
        tick_in = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_valid"}, period_valid, 0);
        chk({tag, "_fast"}, fast, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_count"}, tick_count, 0);
    endtask

    initial begin
        // 1: reset with tick activity
        for (int i = 0; i < 6; i++) begin
            tick_in = ~tick_in;
            step();
        end
        tick_in = 1'b0;
        chk_zero("reset");
        step();
        resetN = 1'b1;
        idle(LAT + 3);
        rise_tick(1);
        idle(20);
        chk("first_count", tick_count, tc_exp);

        // 2: 21-cycle pulses
        for (int i = 0; i < 5; i++) begin
            rise_tick(1);
            idle(20);
        end
        chk("count_21", tick_count, tc_exp);

        // 3: 5-cycle pulses then back to 21
        for (int i = 0; i < 4; i++) begin
            rise_tick(1);
            idle(4);
        end
        chk("fast_set", fast, 1);
        for (int i = 0; i < 3; i++) begin
            rise_tick(1);
            idle(20);
        end
        chk("fast_clr", fast, 0);
        chk("count_mix", tick_count, tc_exp);

        // 4: timeout after silence
        rise_tick(1);
        idle(99 + LAT);
        chk("timeout_early", timeout, 0);
        step();
        chk("timeout_set", timeout, 1);
        idle(30);
        chk("timeout_sticky", timeout, 1);
        rise_tick(1);
        idle(20);
        chk("timeout_clr", timeout, 0);
        rise_tick(1);
        idle(20);
        chk("period_after_stall", period, 21);

        // 5: clear coinciding with a rise at tick_count=7
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_zero("clear_plain");
        measuring = 0;
        tc_exp = 0;
        idle(5);
        for (int i = 0; i < 7; i++) begin
            rise_tick(1);
            idle(6);
        end
        chk("count7", tick_count, 7);
        tick_in = 1'b1;
        idle(LAT);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_zero("clear_rise");
        measuring = 0;
        tc_exp = 0;
        idle(3);
        tick_in = 1'b0;
        idle(LAT + 3);
        chk("clear_no_spurious", tick_count, 0);
        rise_tick(1);
        idle(20);
        rise_tick(1);
        idle(20);
        chk("clear_period", period, 21);
        chk("clear_count", tick_count, 2);

        // 6: duty50 level train
        for (int i = 0; i < 4; i++) begin
            rise_tick(30);
            idle(30);
        end
        chk("duty_period", period, 60);
        chk("duty_count", tick_count, tc_exp);

        idle(5);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
